// File: rtl/pong_pkg.sv
// Shared types and constants for the pong round sequencer.
// Build option: PONG_ROUND_TIMER_EN enables the round time limit.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SCORE_W = 4;
    localparam int TIME_W  = 7;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_HOLDOFF_CYCLES  = 50_000_000;
    localparam int DEF_TARGET_SCORE    = 9;
    localparam int DEF_ROUND_SECONDS   = 30;
    localparam int DEF_TICK_CYCLES     = 100_000_000;

    // Counter width able to hold 0..n (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchroniser and counting debouncer for the active-low IR cup sensor.
// Produces the debounced "object present" level and a registered one-cycle rise strobe.
module ir_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic present,
    output logic rise
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          present_q, present_d;
    logic          prev_q, rise_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level only flips after an unbroken run of disagreement; any agreeing cycle restarts the run.
    always_comb begin
        present_d = present_q;
        cnt_d     = '0;
        if (~sync2_q != present_q) begin
            if (cnt_q == CNT_LAST) begin
                present_d = ~present_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            present_q <= 1'b0;
            prev_q    <= 1'b0;
            rise_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw_n;
            sync2_q   <= sync1_q;
            present_q <= present_d;
            cnt_q     <= cnt_d;
            prev_q    <= present_q;
            rise_q    <= present_q & ~prev_q;
        end
    end

    assign present = present_q;
    assign rise    = rise_q;

endmodule

// File: rtl/pong_round_ctrl.sv
// Pong round sequencer: debounced IR hits, score counting, hit holdoff and round end.
// Build option: define PONG_ROUND_TIMER_EN to add the per-round seconds countdown.
module pong_round_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
    parameter int TARGET_SCORE    = DEF_TARGET_SCORE,
    parameter int ROUND_SECONDS   = DEF_ROUND_SECONDS,
    parameter int TICK_CYCLES     = DEF_TICK_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ir_sensor,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  time_left,
    output logic               led,
    output logic               hit_pulse,
    output logic               round_active,
    output logic               round_done,
    output state_t             state_dbg
);

    if (TARGET_SCORE < 1 || TARGET_SCORE > 15 || ROUND_SECONDS > 127 || TICK_CYCLES < 1
        || HOLDOFF_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("pong_round_ctrl: parameter out of range");
    end

    localparam int HW = cnt_w(HOLDOFF_CYCLES);
    localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(TARGET_SCORE - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(TARGET_SCORE);

    logic               present, rise;
    state_t             state_q;
    logic [SCORE_W-1:0] score_q;
    logic [HW-1:0]      hold_cnt_q;
    logic               hit_q, led_q;
    logic [TIME_W-1:0]  time_q;
    logic               active, expire, launch;

    ir_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .raw_n  (ir_sensor),
        .present(present),
        .rise   (rise)
    );

    assign active = (state_q == ARMED) || (state_q == HOLDOFF);
    assign launch = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef PONG_ROUND_TIMER_EN
    localparam int TKW = cnt_w(TICK_CYCLES);
    localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_CYCLES - 1);

    logic [TKW-1:0] tick_q;
    logic           tick_wrap;

    assign tick_wrap = (tick_q == TICK_LAST);
    // Expiry is the tick that takes time_left from 1 to 0.
    assign expire    = active && tick_wrap && (time_q == TIME_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            time_q <= '0;
        end else if (launch) begin
            tick_q <= '0;
            time_q <= TIME_W'(ROUND_SECONDS);
        end else if (active) begin
            if (tick_wrap) begin
                tick_q <= '0;
                if (time_q != '0) begin
                    time_q <= time_q - TIME_W'(1);
                end
            end else begin
                tick_q <= tick_q + TKW'(1);
            end
        end
    end
`else
    assign expire = 1'b0;
    assign time_q = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            score_q    <= '0;
            hold_cnt_q <= '0;
            hit_q      <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            led_q <= present;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARMED;
                        score_q <= '0;
                    end
                end
                ARMED: begin
                    // A hit on the expiry cycle still scores before the round closes.
                    if (rise) begin
                        hit_q <= 1'b1;
                        if (score_q != SCORE_MAX) begin
                            score_q <= score_q + SCORE_W'(1);
                        end
                        hold_cnt_q <= '0;
                        if ((score_q == SCORE_LAST) || expire) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= HOLDOFF;
                        end
                    end else if (expire) begin
                        state_q <= DONE;
                    end
                end
                HOLDOFF: begin
                    if (expire) begin
                        state_q <= DONE;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        if (!present) begin
                            state_q <= ARMED;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= ARMED;
                        score_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign score        = score_q;
    assign time_left    = time_q;
    assign led          = led_q;
    assign hit_pulse    = hit_q;
    assign round_active = active;
    assign round_done   = (state_q == DONE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Self-checking bench for pong_round_ctrl with short debounce/holdoff/tick settings.
// Build option: PONG_ROUND_TIMER_EN selects the timer scenarios.
module tb_pong_round_ctrl;
    import pong_pkg::*;

    localparam int DEB    = 4;
    localparam int HOLD   = 10;
    localparam int TICK   = 20;
    localparam int SECS   = 3;
    localparam int TARGET = 9;

    logic               clk;
    logic               rst;
    logic               start;
    logic               ir_sensor;
    logic [SCORE_W-1:0] score;
    logic [TIME_W-1:0]  time_left;
    logic               led;
    logic               hit_pulse;
    logic               round_active;
    logic               round_done;
    state_t             state_dbg;

    int total = 0;
    int bad   = 0;
    int model_score = 0;
    logic [SCORE_W-1:0] exp_q[$];

    pong_round_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD),
        .TARGET_SCORE   (TARGET),
        .ROUND_SECONDS  (SECS),
        .TICK_CYCLES    (TICK)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ir_sensor   (ir_sensor),
        .score       (score),
        .time_left   (time_left),
        .led         (led),
        .hit_pulse   (hit_pulse),
        .round_active(round_active),
        .round_done  (round_done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : sb_monitor
        logic [SCORE_W-1:0] e;
        if (!rst && hit_pulse) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_hit: hit_pulse=1 score=%0d, required no hit", score);
            end else begin
                e = exp_q.pop_front();
                if (score !== e) begin
                    bad++;
                    $display("FAIL hit_score: score=%0d, required %0d", score, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst       = 1'b1;
        start     = 1'b0;
        ir_sensor = 1'b1;
        exp_q.delete();
        model_score = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic entry(input int low_cycles, input bit expect_hit);
        @(negedge clk);
        if (expect_hit) begin
            model_score++;
            exp_q.push_back(SCORE_W'(model_score));
        end
        ir_sensor = 1'b0;
        repeat (low_cycles) @(negedge clk);
        ir_sensor = 1'b1;
    endtask

    task automatic wait_armed(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (state_dbg == ARMED) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        apply_reset();
        total++;
        if ({score, time_left, led, hit_pulse, round_active, round_done} !== '0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_state: outs=%h state=%0d, required 0 and IDLE",
                     {score, time_left, led, hit_pulse, round_active, round_done}, state_dbg);
        end
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            entry(10, 1'b1);
            if (i < 2) begin
                wait_armed(ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL rearm_timeout: state=%0d, required ARMED", state_dbg);
                end
            end
        end
        total++;
        if (state_dbg !== HOLDOFF || score !== 4'd3) begin
            bad++;
            $display("FAIL pre_reset: state=%0d score=%0d, required HOLDOFF and 3", state_dbg, score);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({score, time_left, led, hit_pulse, round_active, round_done} !== '0) begin
            bad++;
            $display("FAIL async_reset: outs=%h, required 0",
                     {score, time_left, led, hit_pulse, round_active, round_done});
        end
        @(posedge clk);
        #1;
        total++;
        if (state_dbg !== IDLE || score !== '0 || led !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: state=%0d score=%0d led=%b, required IDLE 0 0", state_dbg, score, led);
        end
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_hits: %0d left, required 0", exp_q.size());
        end
        exp_q.delete();
        model_score = 0;
        pulse_start();
        total++;
        if (score !== '0 || state_dbg !== ARMED) begin
            bad++;
            $display("FAIL restart_after_reset: score=%0d state=%0d, required 0 ARMED", score, state_dbg);
        end
    endtask

    task automatic test_single_hit();
        int n;
        apply_reset();
        pulse_start();
        @(negedge clk);
        model_score++;
        exp_q.push_back(SCORE_W'(model_score));
        ir_sensor = 1'b0;
        n = 1;
        while (n <= 20) begin
            @(posedge clk);
            #1;
            if (hit_pulse) break;
            n++;
        end
        total++;
        if (n != DEB + 4) begin
            bad++;
            $display("FAIL hit_latency: cycles=%0d, required %0d", n, DEB + 4);
        end
        total++;
        if (score !== 4'd1 || state_dbg !== HOLDOFF) begin
            bad++;
            $display("FAIL first_hit: score=%0d state=%0d, required 1 HOLDOFF", score, state_dbg);
        end
        @(posedge clk);
        #1;
        total++;
        if (hit_pulse !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width: hit_pulse=%b, required 0", hit_pulse);
        end
        repeat (2) @(negedge clk);
        ir_sensor = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_hit: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_glitch();
        bit led_seen;
        apply_reset();
        pulse_start();
        led_seen = 1'b0;
        for (int r = 0; r < 6; r++) begin
            ir_sensor = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (led) led_seen = 1'b1;
            end
            ir_sensor = 1'b1;
            repeat ($urandom_range(3, 6)) begin
                @(negedge clk);
                if (led) led_seen = 1'b1;
            end
        end
        repeat (8) begin
            @(negedge clk);
            if (led) led_seen = 1'b1;
        end
        total++;
        if (led_seen !== 1'b0) begin
            bad++;
            $display("FAIL glitch_led: led went 1, required 0");
        end
        total++;
        if (score !== '0 || state_dbg !== ARMED) begin
            bad++;
            $display("FAIL glitch_score: score=%0d state=%0d, required 0 ARMED", score, state_dbg);
        end
    endtask

    task automatic test_holdoff_held();
        bit ok;
        apply_reset();
        pulse_start();
        @(negedge clk);
        model_score++;
        exp_q.push_back(SCORE_W'(model_score));
        ir_sensor = 1'b0;
        repeat (35) @(negedge clk);
        total++;
        if (state_dbg !== HOLDOFF || score !== 4'd1 || led !== 1'b1) begin
            bad++;
            $display("FAIL held_holdoff: state=%0d score=%0d led=%b, required HOLDOFF 1 1",
                     state_dbg, score, led);
        end
        repeat (10) @(negedge clk);
        ir_sensor = 1'b1;
        wait_armed(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL release_rearm: state=%0d, required ARMED", state_dbg);
        end
        entry(10, 1'b1);
        repeat (10) @(negedge clk);
        total++;
        if (score !== 4'd2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL second_entry: score=%0d pending=%0d, required 2 0", score, exp_q.size());
        end
    endtask

    task automatic test_target();
        bit ok;
        apply_reset();
        pulse_start();
        for (int i = 1; i <= TARGET; i++) begin
            entry($urandom_range(8, 14), 1'b1);
            if (i < TARGET) begin
                wait_armed(ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL target_rearm: hit %0d state=%0d, required ARMED", i, state_dbg);
                end
            end
        end
        repeat (5) @(negedge clk);
        total++;
        if (score !== 4'(TARGET) || round_done !== 1'b1 || round_active !== 1'b0) begin
            bad++;
            $display("FAIL target_done: score=%0d done=%b active=%b, required %0d 1 0",
                     score, round_done, round_active, TARGET);
        end
        repeat (20) @(negedge clk);
        entry(10, 1'b0);
        repeat (15) @(negedge clk);
        total++;
        if (score !== 4'(TARGET) || state_dbg !== DONE) begin
            bad++;
            $display("FAIL tenth_entry: score=%0d state=%0d, required %0d DONE", score, state_dbg, TARGET);
        end
        pulse_start();
        total++;
        if (score !== '0 || state_dbg !== ARMED || round_done !== 1'b0) begin
            bad++;
            $display("FAIL done_restart: score=%0d state=%0d done=%b, required 0 ARMED 0",
                     score, state_dbg, round_done);
        end
    endtask

    task automatic test_timer();
        apply_reset();
        pulse_start();
`ifdef PONG_ROUND_TIMER_EN
        total++;
        if (time_left !== 7'(SECS)) begin
            bad++;
            $display("FAIL time_load: time_left=%0d, required %0d", time_left, SECS);
        end
        for (int k = SECS - 1; k >= 0; k--) begin
            repeat (TICK - 1) @(negedge clk);
            total++;
            if (time_left !== 7'(k + 1)) begin
                bad++;
                $display("FAIL tick_early: time_left=%0d, required %0d", time_left, k + 1);
            end
            @(negedge clk);
            total++;
            if (time_left !== 7'(k)) begin
                bad++;
                $display("FAIL tick_step: time_left=%0d, required %0d", time_left, k);
            end
        end
        total++;
        if (round_done !== 1'b1 || state_dbg !== DONE || score !== '0) begin
            bad++;
            $display("FAIL timeout_done: done=%b state=%0d score=%0d, required 1 DONE 0",
                     round_done, state_dbg, score);
        end
        pulse_start();
        repeat (SECS * TICK - DEB - 4) @(negedge clk);
        model_score = 1;
        exp_q.push_back(SCORE_W'(1));
        ir_sensor = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        total++;
        if (round_done !== 1'b1 || score !== 4'd1 || time_left !== '0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL hit_on_expiry: done=%b score=%0d time=%0d pending=%0d, required 1 1 0 0",
                     round_done, score, time_left, exp_q.size());
        end
        ir_sensor = 1'b1;
        repeat (10) @(negedge clk);
`else
        repeat (100) @(negedge clk);
        total++;
        if (time_left !== '0 || round_done !== 1'b0 || state_dbg !== ARMED) begin
            bad++;
            $display("FAIL no_timer: time=%0d done=%b state=%0d, required 0 0 ARMED",
                     time_left, round_done, state_dbg);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ir_sensor = 1'b1;
`ifndef PONG_ROUND_TIMER_EN
        test_reset();
`endif
        test_single_hit();
        test_glitch();
`ifndef PONG_ROUND_TIMER_EN
        test_holdoff_held();
        test_target();
`endif
        test_timer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
